apb_transfer_sequencer: RTL and testbench
=========================================

Name: apb_transfer_sequencer

Overview:
- Downstream consumer of the bridge's positive-edge detector.
- Takes the single-cycle `start` pulse the detector produces, plus the latched AHB-side request fields.
- Runs one complete APB3 transfer (SETUP then ACCESS), inserting wait states on PREADY and aborting after a bounded timeout.
- Holds one further request in a one-deep pending buffer, so a pulse arriving mid-transfer is not lost. Returns a one-cycle completion pulse with read data and status.

Parameters:
- ADDR_WIDTH, 32, width of paddr / req_addr.
- DATA_WIDTH, 32, width of pwdata / prdata / req_wdata / rdata.
- TIMEOUT, 16, number of consecutive ACCESS cycles with pready low before abort; legal range 1..255.

Ports:
- clk  input  1  bridge clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request pulse from the edge detector.
- req_write  input  1  1 = write, 0 = read; sampled with start.
- req_addr  input  ADDR_WIDTH  transfer address; sampled with start.
- req_wdata  input  DATA_WIDTH  write data; sampled with start.
- paddr  output  ADDR_WIDTH  APB address.
- pwrite  output  1  APB direction.
- pwdata  output  DATA_WIDTH  APB write data.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- prdata  input  DATA_WIDTH  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB slave error.
- rdata  output  DATA_WIDTH  captured read data; held until the next read completes.
- done  output  1  one-cycle completion pulse.
- error  output  1  valid with done: pslverr or timeout.
- timeout  output  1  valid with done: the abort was caused by timeout.
- busy  output  1  high while not IDLE or while pending is full.
- overrun  output  1  one-cycle pulse when a start is dropped.

Behaviour:
- Reset (async, rst_n low): every output is 0; state goes to IDLE; pending buffer and wait counter are cleared. psel/penable drop immediately, including mid-transfer; an in-flight or pending request is discarded and no done is issued.
- All outputs are registered.
- States: IDLE(00), SETUP(01), ACCESS(10).
- IDLE:
  - start=1: latch the request into paddr/pwrite/pwdata, then SETUP.
  - Otherwise stay in IDLE with psel=0.
- SETUP:
  - psel=1, penable=0.
  - Unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata stable.
  - pready=1: in the next cycle, done=1 and error=pslverr; if a read, rdata=prdata. Then:
    - pending full: load the pending request, go to SETUP. psel stays 1, penable=0.
    - pending empty: go to IDLE, psel=0.
  - pready=0: increment the wait counter. When TIMEOUT consecutive low samples have accumulated, abort: done=1, error=1, timeout=1, psel/penable deasserted, rdata unchanged. Next state follows the same pending rule as a normal completion.
  - pready=1 on the same cycle the counter would expire: pready wins, normal completion.
  - The wait counter clears on entry to SETUP.
- Latency: start in cycle 0 gives psel in cycle 1 and penable in cycle 2. With zero wait states, done is in cycle 3.
- Pending buffer (one deep):
  - start while state is not IDLE and pending is empty: capture the request, pending=1.
  - start while pending is full: drop the request, overrun=1 for one cycle.
  - start in the same cycle pending is being consumed: the new request is captured (the freed slot is reused); no overrun.
- done and overrun never stay high for 2 consecutive cycles unless caused by consecutive events.
- busy = (state != IDLE) | pending.

Decomposition:
- Shared package (bridge_pkg) holds:
  - state encoding constants IDLE/SETUP/ACCESS;
  - default ADDR_WIDTH/DATA_WIDTH;
  - APB response encoding (OKAY/ERROR).
- One natural sub-module: apb_req_buffer. It is the one-deep pending register holding write/addr/wdata, with capture, consume and overrun logic. The FSM and wait counter stay in the top module.

Test Plan:
- Read, zero wait: start in cycle 0 with req_addr=0x40, req_write=0; pready=1, prdata=0xDEADBEEF in cycle 2 -> psel=1 in cycles 1-2, penable=1 in cycle 2, done=1 and rdata=0xDEADBEEF in cycle 3, error=0.
- Write, 3 wait states: req_wdata=0x12345678; pready low in cycles 2-4, high in cycle 5 -> pwdata stable through cycle 5, done in cycle 6, rdata unchanged.
- Timeout (TIMEOUT=16): pready held low -> in cycle 18, done=error=timeout=1 and psel=0. Separate run with pready=1 in cycle 17 -> normal completion, timeout=0.
- Pending and overrun: start at cycle 0, 1 and 2 (cycle 1 request addr 0x80) -> cycle 1 is captured as pending; cycle 2 gives overrun=1 in cycle 3. After the first done, the next SETUP uses paddr=0x80 with psel never dropping.
- Slave error: pslverr=1 with pready=1 -> done=1, error=1, timeout=0.
- Reset mid-ACCESS: rst_n low in cycle 2 -> psel/penable/busy go to 0 asynchronously, pending is cleared, and no done follows the release of reset.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared encodings and defaults for the AHB-to-APB bridge blocks.
package bridge_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } apb_resp_t;

endpackage

// File: rtl/apb_req_buffer.sv
// One-deep pending request register: captures a start that arrives while the
// sequencer is occupied, hands it over on consume, and flags dropped starts.
module apb_req_buffer
    import bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  bypass,
    input  logic                  consume,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  pend_valid,
    output logic                  pend_write,
    output logic [ADDR_WIDTH-1:0] pend_addr,
    output logic [DATA_WIDTH-1:0] pend_wdata,
    output logic                  overrun
);

    logic take;
    logic capture;

    // A start not taken directly by an idle sequencer lands here; a slot being
    // consumed this cycle counts as free.
    assign take    = start && !bypass;
    assign capture = take && (!pend_valid || consume);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_write <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= take && pend_valid && !consume;
            if (capture) begin
                pend_valid <= 1'b1;
                pend_write <= req_write;
                pend_addr  <= req_addr;
                pend_wdata <= req_wdata;
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_transfer_sequencer.sv
// Runs one APB3 transfer (SETUP then ACCESS) per start pulse, with wait-state
// timeout and a one-deep pending request; reports completion as a pulse.
module apb_transfer_sequencer
    import bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  error,
    output logic                  timeout,
    output logic                  busy,
    output logic                  overrun,
    output state_t                state_dbg
);

    // Handshake: start is a one-cycle valid with no ready; the sequencer never
    // back-pressures. busy is advisory, and a start that finds both the
    // sequencer and the pending slot occupied is dropped and flagged by overrun.

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                state;
    logic [7:0]            wait_cnt;
    logic                  pend_valid;
    logic                  pend_write;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [DATA_WIDTH-1:0] pend_wdata;
    logic                  access_end;
    logic                  consume;
    logic                  bypass;
    logic                  nxt_write;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [DATA_WIDTH-1:0] nxt_wdata;

    assign access_end = (state == ACCESS) && (pready || (wait_cnt == WAIT_LAST));
    assign consume    = pend_valid && ((state == IDLE) || access_end);
    assign bypass     = (state == IDLE) && !pend_valid;
    assign state_dbg  = state;

    // The pending request always goes ahead of a fresh start.
    assign nxt_write = pend_valid ? pend_write : req_write;
    assign nxt_addr  = pend_valid ? pend_addr  : req_addr;
    assign nxt_wdata = pend_valid ? pend_wdata : req_wdata;

    apb_req_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_req_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bypass     (bypass),
        .consume    (consume),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .pend_valid (pend_valid),
        .pend_write (pend_write),
        .pend_addr  (pend_addr),
        .pend_wdata (pend_wdata),
        .overrun    (overrun)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            paddr    <= '0;
            pwrite   <= 1'b0;
            pwdata   <= '0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            rdata    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            timeout  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done    <= 1'b0;
            error   <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b1;
            case (state)
                IDLE: begin
                    busy <= pend_valid || start;
                    if (pend_valid || start) begin
                        paddr    <= nxt_addr;
                        pwrite   <= nxt_write;
                        pwdata   <= nxt_wdata;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (access_end) begin
                        done <= 1'b1;
                        if (pready) begin
                            error <= (apb_resp_t'(pslverr) == RESP_ERROR);
                            if (!pwrite) begin
                                rdata <= prdata;
                            end
                        end else begin
                            error   <= 1'b1;
                            timeout <= 1'b1;
                        end
                        // A start landing this cycle goes into the pending slot.
                        busy    <= pend_valid || start;
                        penable <= 1'b0;
                        if (pend_valid) begin
                            paddr    <= pend_addr;
                            pwrite   <= pend_write;
                            pwdata   <= pend_wdata;
                            psel     <= 1'b1;
                            wait_cnt <= '0;
                            state    <= SETUP;
                        end else begin
                            psel  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_transfer_sequencer.sv
// Directed bench for apb_transfer_sequencer: reads, writes, wait states,
// timeout, pending/overrun, slave error and asynchronous reset.
module tb_apb_transfer_sequencer;
    import bridge_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [DW-1:0] rdata;
    logic          done;
    logic          error;
    logic          timeout;
    logic          busy;
    logic          overrun;
    state_t        state_dbg;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    apb_transfer_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .rdata     (rdata),
        .done      (done),
        .error     (error),
        .timeout   (timeout),
        .busy      (busy),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        start     = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
    endtask

    task automatic drive_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        start     = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    // scoreboard: completed reads pop the oldest expected data
    task automatic check_read(input string tag);
        check({tag, "_q"}, exp_q.size(), 1);
        if (exp_q.size() > 0) check(tag, rdata, exp_q.pop_front());
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        sample();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 0);
        check("rst_paddr", paddr, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", state_dbg, IDLE);
        next_cycle();
        rst_n = 1'b1;

        // read, zero wait states
        next_cycle();
        drive_req(1'b0, 32'h40, 32'h0);
        sample();
        check("rd_c0_psel", psel, 0);
        next_cycle();
        drive_idle();
        sample();
        check("rd_c1_psel", psel, 1);
        check("rd_c1_penable", penable, 0);
        check("rd_c1_paddr", paddr, 32'h40);
        check("rd_c1_busy", busy, 1);
        check("rd_c1_state", state_dbg, SETUP);
        next_cycle();
        pready = 1'b1;
        prdata = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        sample();
        check("rd_c2_psel", psel, 1);
        check("rd_c2_penable", penable, 1);
        check("rd_c2_done", done, 0);
        next_cycle();
        drive_idle();
        sample();
        check("rd_c3_done", done, 1);
        check("rd_c3_error", error, 0);
        check("rd_c3_psel", psel, 0);
        check_read("rd_c3_rdata");
        next_cycle();
        sample();
        check("rd_c4_done", done, 0);
        check("rd_c4_busy", busy, 0);

        // write, three wait states
        next_cycle();
        drive_req(1'b1, 32'h44, 32'h12345678);
        next_cycle();
        drive_idle();
        sample();
        check("wr_c1_pwrite", pwrite, 1);
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            pready = (c == 5);
            sample();
            check("wr_pwdata", pwdata, 32'h12345678);
            check("wr_penable", penable, 1);
            check("wr_done_early", done, 0);
        end
        next_cycle();
        drive_idle();
        sample();
        check("wr_c6_done", done, 1);
        check("wr_c6_error", error, 0);
        check("wr_c6_rdata", rdata, 32'hDEADBEEF);

        // timeout abort (v=0) and pready rescuing the last cycle (v=1)
        for (int v = 0; v < 2; v++) begin
            next_cycle();
            drive_req(1'b0, 32'h48, 32'h0);
            for (int c = 1; c <= 17; c++) begin
                next_cycle();
                start  = 1'b0;
                pready = (v == 1) && (c == 17);
                prdata = (v == 1) ? 32'h0BADF00D : 32'hBAD0BAD0;
                sample();
                check("to_done_early", done, 0);
                check("to_psel", psel, 1);
            end
            if (v == 1) exp_q.push_back(32'h0BADF00D);
            next_cycle();
            drive_idle();
            sample();
            check("to_c18_done", done, 1);
            check("to_c18_error", error, (v == 0));
            check("to_c18_timeout", timeout, (v == 0));
            check("to_c18_psel", psel, 0);
            check("to_c18_penable", penable, 0);
            if (v == 0) check("to_c18_rdata_held", rdata, 32'hDEADBEEF);
            else check_read("to_c18_rdata");
        end

        // slave error
        next_cycle();
        drive_req(1'b0, 32'h60, 32'h0);
        next_cycle();
        drive_idle();
        next_cycle();
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h33334444;
        exp_q.push_back(32'h33334444);
        next_cycle();
        drive_idle();
        sample();
        check("se_done", done, 1);
        check("se_error", error, 1);
        check("se_timeout", timeout, 0);
        check_read("se_rdata");

        // pending capture and overrun
        next_cycle();
        drive_req(1'b0, 32'h50, 32'h0);
        next_cycle();
        drive_req(1'b1, 32'h80, 32'hA5A5A5A5);
        next_cycle();
        drive_req(1'b0, 32'hC0, 32'h0);
        sample();
        check("pd_c2_overrun", overrun, 0);
        check("pd_c2_busy", busy, 1);
        next_cycle();
        drive_idle();
        pready = 1'b1;
        prdata = 32'h11112222;
        exp_q.push_back(32'h11112222);
        sample();
        check("pd_c3_overrun", overrun, 1);
        check("pd_c3_psel", psel, 1);
        next_cycle();
        drive_idle();
        sample();
        check("pd_c4_done", done, 1);
        check_read("pd_c4_rdata");
        check("pd_c4_overrun", overrun, 0);
        check("pd_c4_psel", psel, 1);
        check("pd_c4_penable", penable, 0);
        check("pd_c4_paddr", paddr, 32'h80);
        check("pd_c4_pwrite", pwrite, 1);
        check("pd_c4_pwdata", pwdata, 32'hA5A5A5A5);
        next_cycle();
        pready = 1'b1;
        sample();
        check("pd_c5_penable", penable, 1);
        check("pd_c5_done", done, 0);
        next_cycle();
        drive_idle();
        sample();
        check("pd_c6_done", done, 1);
        check("pd_c6_psel", psel, 0);
        check("pd_c6_busy", busy, 0);
        check("pd_c6_rdata", rdata, 32'h11112222);
        next_cycle();
        sample();
        check("pd_c7_done", done, 0);
        check("pd_c7_state", state_dbg, IDLE);

        // asynchronous reset in ACCESS with a pending request
        next_cycle();
        drive_req(1'b0, 32'h70, 32'h0);
        next_cycle();
        drive_req(1'b1, 32'h74, 32'h55);
        next_cycle();
        drive_idle();
        sample();
        check("ar_c2_penable", penable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_psel", psel, 0);
        check("ar_penable", penable, 0);
        check("ar_busy", busy, 0);
        check("ar_state", state_dbg, IDLE);
        next_cycle();
        next_cycle();
        rst_n  = 1'b1;
        pready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            sample();
            check("ar_done", done, 0);
            check("ar_psel_after", psel, 0);
            check("ar_busy_after", busy, 0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
